cpu_execute: RTL
================

# cpu_execute

Execute stage of the moxie pipeline. Takes decoded operands from the decode/register-read stage, performs ALU, shift, multiply and (optionally) iterative divide operations, and computes effective memory addresses. Registers a result bundle for the writeback unit: control bits, destination index, address, register result and store data. It stalls upstream only while a multi-cycle divide is in flight; downstream never stalls.

## Interface
Parameters:
- DIV_STEPS, 32, divider iterations (one quotient bit per cycle).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-low
- flush_i  in  1  discard the accepted or in-flight op (branch redirect)
- valid_i  in  1  upstream presents an op
- op_i  in  5  ALU opcode (EX_OP_* constants)
- operand_a_i  in  32  rA value
- operand_b_i  in  32  rB value, or immediate
- offset_i  in  32  load/store displacement
- register_write_index_i  in  4  destination register
- pipeline_control_bits_i  in  PCB_WIDTH  control bits (PCB_WR, PCB_WM, PCB_RM, ...)
- PC_i  in  32  instruction PC
- stall_o  out  1  upstream must hold its op
- valid_o  out  1  result bundle valid
- pipeline_control_bits_o  out  PCB_WIDTH  forwarded control bits, all-zero on bubble
- register_write_index_o  out  4
- memory_address_o  out  32  operand_a_i + offset_i
- reg_result_o  out  32  ALU result
- mem_result_o  out  32  store data (operand_b_i)
- PC_o  out  32

## Operation
- Accept = valid_i && !stall_o && !flush_i. An accepted single-cycle op registers all outputs on the same edge.
- Ops: ADD, SUB, AND, OR, XOR, NOT(a), NEG(a), MOV(b), ASHL/LSHR/ASHR (shift amount b[4:0]), MUL (low 32 bits of a*b), DIV/MOD (signed), UDIV/UMOD.
- Arithmetic wraps modulo 2^32; no flags.
- Bubble (no accept, or divide running): valid_o=0 and pipeline_control_bits_o=0, so writeback performs no register or memory write. Other outputs hold their last value.
- FSM has two states:
  - IDLE: accepting a div-class op starts cpu_divider and moves to DIV.
  - DIV: stall_o=1. When divider done, register the result with valid_o=1 and return to IDLE.
- Divide by zero: quotient 0xFFFFFFFF, remainder = dividend.
- Signed 0x80000000 / -1: quotient 0x80000000, remainder 0.
- flush_i has priority over everything:
  - In DIV: abort the divider, go to IDLE, emit no result.
  - In IDLE: the same-cycle op is dropped.
  - Output that edge is a bubble.
- Reset (rst_i=0 at an edge): FSM=IDLE, divider cleared. valid_o=0, stall_o=0, pipeline_control_bits_o=0, register_write_index_o=0, memory_address_o=0, reg_result_o=0, mem_result_o=0, PC_o=0. Reset mid-divide discards the divide.

## Timing
- Single-cycle ops: accepted at edge N, outputs valid after edge N. Throughput is 1 per cycle.
- Divide accepted at edge N:
  - stall_o high during cycles N+1 … N+DIV_STEPS+1.
  - Result registered at edge N+DIV_STEPS+1 (33 cycles); stall_o low after it.
  - Next op accepted no earlier than edge N+DIV_STEPS+2.
- stall_o is a registered-state decode, with no combinational path from valid_i.

## Configuration
- CPU_EXECUTE_DIV_EN defined: cpu_divider is instantiated and the behaviour above applies.
- CPU_EXECUTE_DIV_EN undefined: no divider and no DIV state. Div-class ops complete in one cycle with reg_result_o=0 and control bits forwarded; stall_o is tied 0.

## Structure
- The shared defines package holds:
  - the EX_OP_* opcode constants and the 5-bit op width;
  - PCB_WIDTH and the PCB_* bit indices, shared with decode and writeback.
- Sub-module cpu_divider: restoring shift-subtract unit.
  - Inputs: start, abort, signed, want_rem, a, b.
  - Outputs: busy, done, result.
  - Handles sign fix-up and the zero/overflow corner cases internally.

## Test plan
- ADD 0xFFFFFFFF + 2, PCB_WR set -> next cycle valid_o=1, reg_result_o=0x00000001, pipeline_control_bits_o equals input.
- Store with a=0x1000, offset=0xFFFFFFFC, b=0xDEADBEEF -> memory_address_o=0x00000FFC, mem_result_o=0xDEADBEEF.
- DIV -7/2 -> stall_o high 33 cycles, then reg_result_o=0xFFFFFFFD. MOD gives 0xFFFFFFFF. UDIV 5/0 gives 0xFFFFFFFF.
- Back-to-back ADD, DIV, ADD held by upstream -> the second ADD completes exactly one cycle after the divide result; no duplicate or lost op.
- flush_i at cycle 10 of a divide -> no valid_o for that op, stall_o low next cycle, next op executes normally.
- rst_i low mid-divide -> all outputs zero, stall_o=0. First op after release executes in one cycle.

Source files
------------

// File: rtl/cpu_execute_pkg.sv
// ---------------------------------------------------------------------------
// cpu_execute_pkg
// Shared definitions for the moxie execute stage, also used by decode and
// writeback: ALU opcode encodings, pipeline control bit layout and small
// opcode classification helpers.
// ---------------------------------------------------------------------------
package cpu_execute_pkg;

  localparam int EX_OP_WIDTH = 5;

  // Pipeline control bits travelling with each op.
  localparam int PCB_WIDTH = 4;
  localparam int PCB_WR    = 0;  // write register file
  localparam int PCB_WM    = 1;  // write memory (store)
  localparam int PCB_RM    = 2;  // read memory (load)
  localparam int PCB_HALT  = 3;  // halt request

  localparam logic [EX_OP_WIDTH-1:0] EX_OP_ADD  = 5'd0;
  localparam logic [EX_OP_WIDTH-1:0] EX_OP_SUB  = 5'd1;
  localparam logic [EX_OP_WIDTH-1:0] EX_OP_AND  = 5'd2;
  localparam logic [EX_OP_WIDTH-1:0] EX_OP_OR   = 5'd3;
  localparam logic [EX_OP_WIDTH-1:0] EX_OP_XOR  = 5'd4;
  localparam logic [EX_OP_WIDTH-1:0] EX_OP_NOT  = 5'd5;
  localparam logic [EX_OP_WIDTH-1:0] EX_OP_NEG  = 5'd6;
  localparam logic [EX_OP_WIDTH-1:0] EX_OP_MOV  = 5'd7;
  localparam logic [EX_OP_WIDTH-1:0] EX_OP_ASHL = 5'd8;
  localparam logic [EX_OP_WIDTH-1:0] EX_OP_LSHR = 5'd9;
  localparam logic [EX_OP_WIDTH-1:0] EX_OP_ASHR = 5'd10;
  localparam logic [EX_OP_WIDTH-1:0] EX_OP_MUL  = 5'd11;
  localparam logic [EX_OP_WIDTH-1:0] EX_OP_DIV  = 5'd12;
  localparam logic [EX_OP_WIDTH-1:0] EX_OP_MOD  = 5'd13;
  localparam logic [EX_OP_WIDTH-1:0] EX_OP_UDIV = 5'd14;
  localparam logic [EX_OP_WIDTH-1:0] EX_OP_UMOD = 5'd15;

  // True for the four divider-class opcodes.
  function automatic logic is_div_op(input logic [EX_OP_WIDTH-1:0] op);
    return (op == EX_OP_DIV) || (op == EX_OP_MOD) ||
           (op == EX_OP_UDIV) || (op == EX_OP_UMOD);
  endfunction

  function automatic logic div_is_signed(input logic [EX_OP_WIDTH-1:0] op);
    return (op == EX_OP_DIV) || (op == EX_OP_MOD);
  endfunction

  function automatic logic div_want_rem(input logic [EX_OP_WIDTH-1:0] op);
    return (op == EX_OP_MOD) || (op == EX_OP_UMOD);
  endfunction

endpackage

// File: rtl/cpu_execute_divider.sv
// ---------------------------------------------------------------------------
// cpu_divider
// Iterative restoring shift-subtract divider, one quotient bit per cycle.
// Signed ops divide magnitudes and fix the signs afterwards (quotient negative
// when operand signs differ, remainder takes the dividend's sign).
// Divide by zero returns quotient 0xFFFFFFFF and remainder = dividend.
// Signed 0x80000000 / -1 falls out of the magnitude path naturally:
// 0x80000000 / 1 with no sign change gives 0x80000000, remainder 0.
//
// Ports:
//   clk_i, rst_i  clock, synchronous active-low reset
//   start         load operands and begin (ignored while abort is high)
//   abort         drop the operation in flight
//   is_signed     signed division
//   want_rem      result is the remainder instead of the quotient
//   a, b          dividend, divisor
//   busy          operation in flight
//   done          result valid this cycle (one cycle, while busy)
//   result        quotient or remainder
// ---------------------------------------------------------------------------
module cpu_divider #(
  parameter int DIV_STEPS = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start,
  input  logic        abort,
  input  logic        is_signed,
  input  logic        want_rem,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int CNT_W = $clog2(DIV_STEPS + 1);

  logic [CNT_W-1:0] count;
  logic [31:0]      rem;
  logic [31:0]      quo;
  logic [31:0]      divisor;
  logic [31:0]      dividend;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;
  logic             rem_sel;

  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] rem_shift;
  logic [32:0] diff;

  assign mag_a = (is_signed && a[31]) ? -a : a;
  assign mag_b = (is_signed && b[31]) ? -b : b;

  // Partial remainder shifted left with the next dividend bit. It is always
  // below 2*divisor, so bit 32 of the difference is a clean "does not fit".
  assign rem_shift = {rem, quo[31]};
  assign diff      = rem_shift - {1'b0, divisor};

  assign done = busy && (count == '0);

  assign result = div_zero ? (rem_sel ? dividend : 32'hFFFF_FFFF)
                : rem_sel  ? (neg_r ? -rem : rem)
                :            (neg_q ? -quo : quo);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      busy     <= 1'b0;
      count    <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      dividend <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      rem_sel  <= 1'b0;
    end else if (abort) begin
      busy  <= 1'b0;
      count <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      count    <= CNT_W'(DIV_STEPS);
      rem      <= '0;
      quo      <= mag_a;
      divisor  <= mag_b;
      dividend <= a;
      neg_q    <= is_signed && (a[31] ^ b[31]);
      neg_r    <= is_signed && a[31];
      div_zero <= (b == '0);
      rem_sel  <= want_rem;
    end else if (busy) begin
      if (count != '0) begin
        count <= count - CNT_W'(1);
        if (!diff[32]) begin
          rem <= diff[31:0];
          quo <= {quo[30:0], 1'b1};
        end else begin
          rem <= rem_shift[31:0];
          quo <= {quo[30:0], 1'b0};
        end
      end else begin
        busy <= 1'b0;  // result consumed by the stage this cycle
      end
    end
  end

endmodule

// File: rtl/cpu_execute.sv
// ---------------------------------------------------------------------------
// cpu_execute
// Execute stage of the moxie pipeline. Performs ALU, shift and multiply ops
// in one cycle, computes load/store effective addresses and registers a
// result bundle for writeback. Divider-class ops use the iterative
// cpu_divider and stall upstream while it runs.
//
// Build option: define CPU_EXECUTE_DIV_EN to include the divider. Without it
// divider-class ops complete in one cycle with a zero result and stall_o is 0.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-low reset
//   flush_i                  drop the accepted / in-flight op
//   valid_i                  upstream presents an op
//   op_i                     EX_OP_* opcode
//   operand_a_i/operand_b_i  rA, rB-or-immediate
//   offset_i                 load/store displacement
//   register_write_index_i   destination register
//   pipeline_control_bits_i  PCB_* control bits
//   PC_i                     instruction PC
//   stall_o                  upstream must hold (divide in flight)
//   valid_o                  result bundle valid
//   pipeline_control_bits_o  forwarded control bits, zero on bubble
//   register_write_index_o   destination register
//   memory_address_o         operand_a + offset
//   reg_result_o             ALU result
//   mem_result_o             store data (operand_b)
//   PC_o                     instruction PC
// ---------------------------------------------------------------------------
module cpu_execute
  import cpu_execute_pkg::*;
#(
  parameter int DIV_STEPS = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   valid_i,
  input  logic [EX_OP_WIDTH-1:0] op_i,
  input  logic [31:0]            operand_a_i,
  input  logic [31:0]            operand_b_i,
  input  logic [31:0]            offset_i,
  input  logic [3:0]             register_write_index_i,
  input  logic [PCB_WIDTH-1:0]   pipeline_control_bits_i,
  input  logic [31:0]            PC_i,
  output logic                   stall_o,
  output logic                   valid_o,
  output logic [PCB_WIDTH-1:0]   pipeline_control_bits_o,
  output logic [3:0]             register_write_index_o,
  output logic [31:0]            memory_address_o,
  output logic [31:0]            reg_result_o,
  output logic [31:0]            mem_result_o,
  output logic [31:0]            PC_o
);

  if (DIV_STEPS < 1 || DIV_STEPS > 32) begin : g_div_steps_check
    $error("cpu_execute: DIV_STEPS must be in 1..32");
  end

  logic [31:0] alu_result;
  logic        issue_single;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    alu_result = '0;
    case (op_i)
      EX_OP_ADD:  alu_result = operand_a_i + operand_b_i;
      EX_OP_SUB:  alu_result = operand_a_i - operand_b_i;
      EX_OP_AND:  alu_result = operand_a_i & operand_b_i;
      EX_OP_OR:   alu_result = operand_a_i | operand_b_i;
      EX_OP_XOR:  alu_result = operand_a_i ^ operand_b_i;
      EX_OP_NOT:  alu_result = ~operand_a_i;
      EX_OP_NEG:  alu_result = -operand_a_i;
      EX_OP_MOV:  alu_result = operand_b_i;
      EX_OP_ASHL: alu_result = operand_a_i << operand_b_i[4:0];
      EX_OP_LSHR: alu_result = operand_a_i >> operand_b_i[4:0];
      EX_OP_ASHR: alu_result = $unsigned($signed(operand_a_i) >>> operand_b_i[4:0]);
      EX_OP_MUL:  alu_result = operand_a_i * operand_b_i;
      default:    alu_result = '0;  // divider class without divider, unused codes
    endcase
  end

`ifdef CPU_EXECUTE_DIV_EN
  typedef enum logic {ST_IDLE, ST_DIV} state_t;

  state_t      state;
  logic        div_start;
  logic        div_abort;
  logic        div_busy;
  logic        div_done;
  logic        div_finish;
  logic [31:0] div_result;

  // Bundle of the divide op, held until the divider finishes so the visible
  // outputs keep their last value during the stall.
  logic [PCB_WIDTH-1:0] pend_pcb;
  logic [3:0]           pend_index;
  logic [31:0]          pend_addr;
  logic [31:0]          pend_store;
  logic [31:0]          pend_pc;

  assign stall_o      = (state == ST_DIV);
  assign issue_single = valid_i && !flush_i && (state == ST_IDLE) && !is_div_op(op_i);
  assign div_start    = valid_i && !flush_i && (state == ST_IDLE) && is_div_op(op_i);
  assign div_abort    = flush_i && (state == ST_DIV);
  assign div_finish   = div_busy && div_done;

  cpu_divider #(
    .DIV_STEPS (DIV_STEPS)
  ) u_divider (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start     (div_start),
    .abort     (div_abort),
    .is_signed (div_is_signed(op_i)),
    .want_rem  (div_want_rem(op_i)),
    .a         (operand_a_i),
    .b         (operand_b_i),
    .busy      (div_busy),
    .done      (div_done),
    .result    (div_result)
  );

  // NOTE: these holding registers have no reset; they are only read after a
  // divide start has loaded them, so resetting them would add logic for
  // nothing.
  always_ff @(posedge clk_i) begin
    if (div_start) begin
      pend_pcb   <= pipeline_control_bits_i;
      pend_index <= register_write_index_i;
      pend_addr  <= operand_a_i + offset_i;
      pend_store <= operand_b_i;
      pend_pc    <= PC_i;
    end
  end
`else
  assign stall_o      = 1'b0;
  assign issue_single = valid_i && !flush_i;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
`ifdef CPU_EXECUTE_DIV_EN
      state <= ST_IDLE;
`endif
      valid_o                 <= 1'b0;
      pipeline_control_bits_o <= '0;
      register_write_index_o  <= '0;
      memory_address_o        <= '0;
      reg_result_o            <= '0;
      mem_result_o            <= '0;
      PC_o                    <= '0;
    end else begin
      // Bubble unless something below completes this edge.
      valid_o                 <= 1'b0;
      pipeline_control_bits_o <= '0;

      if (issue_single) begin
        valid_o                 <= 1'b1;
        pipeline_control_bits_o <= pipeline_control_bits_i;
        register_write_index_o  <= register_write_index_i;
        memory_address_o        <= operand_a_i + offset_i;
        reg_result_o            <= alu_result;
        mem_result_o            <= operand_b_i;
        PC_o                    <= PC_i;
      end

`ifdef CPU_EXECUTE_DIV_EN
      if (flush_i) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (div_start) state <= ST_DIV;
          ST_DIV: begin
            if (div_finish) begin
              valid_o                 <= 1'b1;
              pipeline_control_bits_o <= pend_pcb;
              register_write_index_o  <= pend_index;
              memory_address_o        <= pend_addr;
              reg_result_o            <= div_result;
              mem_result_o            <= pend_store;
              PC_o                    <= pend_pc;
              state                   <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
`endif
    end
  end

endmodule
